mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between instruction-fetch (I) and data load/store (D) requesters.
- Serializes requests, with one transaction in flight at a time.
- Routes each read response back to the requester that issued it.
- Sits between the fetch/ICache path and DCache path on one side and the Memory151 interface on the other.

Parameters:
- ADDR_W, 28: memory address width (line address).
- DATA_W, 128: memory data width; mask width is DATA_W/8.
- STARVE_LIMIT, 4: consecutive D grants while I is waiting before I is forced to win; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  I-side read request.
- i_req_addr  in  ADDR_W  I-side address.
- i_req_ready  out  1  I request accepted this cycle.
- i_resp_valid  out  1  I read data valid, one-cycle pulse.
- i_resp_data  out  DATA_W  I read data.
- d_req_valid  in  1  D-side request.
- d_req_rw  in  1  1 = write, 0 = read.
- d_req_addr  in  ADDR_W  D address.
- d_req_wdata  in  DATA_W  D write data.
- d_req_wmask  in  DATA_W/8  D byte write mask.
- d_req_ready  out  1  D request accepted this cycle.
- d_resp_valid  out  1  D read data valid, one-cycle pulse.
- d_resp_data  out  DATA_W  D read data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_rw  out  1  1 = write.
- mem_req_addr  out  ADDR_W  memory address.
- mem_req_wdata  out  DATA_W  write data.
- mem_req_wmask  out  DATA_W/8  write mask; all zero for reads.
- mem_resp_valid  in  1  memory read data valid.
- mem_resp_data  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. Registers: state, owner (0 = I, 1 = D), rw, addr, wdata, wmask, starve_cnt (4 bits).
- Reset (reset == 0, asynchronous):
  - state = IDLE, starve_cnt = 0, owner = 0, all latched fields = 0.
  - All outputs are 0, including mem_req_valid, both ready and resp_valid signals, and busy.
- Arbitration in IDLE (combinational):
  - Only D valid -> D granted. Only I valid -> I granted.
  - Both valid -> D granted unless starve_cnt == STARVE_LIMIT, in which case I is granted.
  - x_req_ready = 1 only in IDLE and only for the granted side; never both at once. ready does not depend on mem_req_ready.
- Handshake on valid && ready:
  - Latch owner, addr, and rw (I forces rw = 0, wmask = 0); latch wdata and wmask from D.
  - Next state = ISSUE.
- starve_cnt update on each grant:
  - D granted while i_req_valid = 1 -> starve_cnt + 1, saturating at STARVE_LIMIT.
  - I granted -> 0.
  - Otherwise unchanged.
- ISSUE:
  - mem_req_valid = 1; mem_req_* driven from the latched registers, so they are stable for the whole ISSUE state.
  - On mem_req_ready: write -> IDLE (no response); read -> WAIT.
- WAIT:
  - On mem_resp_valid, for exactly that cycle: owner's resp_valid = 1 (combinational), owner's resp_data = mem_resp_data; then -> IDLE.
  - Non-owner resp_valid stays 0.
- resp_data ports always carry mem_resp_data; they are qualified only by the matching resp_valid.
- mem_resp_valid outside WAIT is ignored.
- Requesters must hold addr/data stable while valid and not ready. Dropping valid before ready (e.g., fetch squashed by a jump or pc_sel flush) is legal; nothing is latched.
- Back-to-back operation: IDLE is visited for at least one cycle between transactions. Minimum spacing is 2 cycles per write and 3 cycles per read.
- Reset asserted mid-transaction: FSM returns to IDLE and the in-flight response is dropped. Requesters are reset by the same signal.
- Latency: request handshake to mem_req_valid = 1 cycle. mem_resp_valid to x_resp_valid = 0 cycles.

Test Plan:
- Single I read, addr 0x0000010: i_req_ready in cycle 0; mem_req_valid with rw = 0, addr 0x10 in cycle 1; memory ready in cycle 1, resp in cycle 3 with data 0xDEADBEEF... -> i_resp_valid = 1 in cycle 3 only, d_resp_valid = 0, busy falls in cycle 4.
- D write, addr 0x20, mask 0x000F, memory ready delayed 3 cycles -> mem_req_* held constant 4 cycles; no resp pulse; IDLE on the following cycle.
- I and D continuously valid, STARVE_LIMIT = 4 -> grant order D, D, D, D, I, D, D, D, D, I, ...; starve_cnt never exceeds 4.
- I valid for 1 cycle while D owns the port, then dropped -> no I transaction issued; starve_cnt still increments for that grant.
- Spurious mem_resp_valid during IDLE and during ISSUE -> no resp_valid on either side; FSM state unchanged.
- Reset pulled low while in WAIT, mem_resp_valid arrives after release -> all outputs 0 immediately, response ignored, next I request served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises I-fetch reads and D load/stores onto one memory port; ports: clk, reset (async active-low), i_req_*/i_resp_*, d_req_*/d_resp_*, mem_req_*/mem_resp_*, busy
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_req_ready,
  output logic                i_resp_valid,
  output logic [DATA_W-1:0]   i_resp_data,
  input  logic                d_req_valid,
  input  logic                d_req_rw,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wmask,
  output logic                d_req_ready,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic owner, rw_q, idle, gnt_i, gnt_d, hit;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [3:0] starve_cnt;
  always_comb begin
    idle = reset && state == IDLE;
    gnt_d = idle && d_req_valid && !(i_req_valid && starve_cnt == LIM);
    gnt_i = idle && i_req_valid && !gnt_d;
    hit = state == WAIT && mem_resp_valid;
  end
  assign i_req_ready = gnt_i;
  assign d_req_ready = gnt_d;
  assign i_resp_valid = hit && !owner;
  assign d_resp_valid = hit && owner;
  assign i_resp_data = reset ? mem_resp_data : '0;
  assign d_resp_data = reset ? mem_resp_data : '0;
  assign mem_req_valid = state == ISSUE;
  assign mem_req_rw = rw_q;
  assign mem_req_addr = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      starve_cnt <= 4'd0;
    end else if (gnt_i || gnt_d) begin
      state <= ISSUE;
      owner <= gnt_d;
      rw_q <= gnt_d && d_req_rw;
      addr_q <= gnt_d ? d_req_addr : i_req_addr;
      wdata_q <= gnt_d ? d_req_wdata : '0;
      wmask_q <= (gnt_d && d_req_rw) ? d_req_wmask : '0;
      starve_cnt <= gnt_i ? 4'd0 : (i_req_valid && starve_cnt != LIM) ? starve_cnt + 4'd1 : starve_cnt;
    end else if (state == ISSUE && mem_req_ready)
      state <= rw_q ? IDLE : WAIT;
    else if (hit)
      state <= IDLE;
endmodule
